riscv_core: RTL and testbench

- Single-cycle RV32I + Zicsr processor with machine-mode trap handling and an embedded unified instruction/data memory.
- Top-level compute block of the design. Program image is preloaded into the memory array before reset is released.
- Architectural state must be visible hierarchically for checking and dumps:
  - register file array `rs`
  - CSR array `csr`
  - memory instance `memory` holding array `m`
- Pass criterion used by the compliance flow: x3 (gp) == 1 after the program runs.

---
 rtl/riscv_pkg.sv | 84 ++++++++
 rtl/riscv_mem.sv | 36 +++
 rtl/riscv_core.sv | 273 +++++++++++++++++++++++++++
 tb/tb_riscv_core.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I/Zicsr decode constants, CSR addresses, cause codes and ALU ops.
// Optional cycle/instret counters are enabled by RISCV_CORE_COUNTERS_EN.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_PRIV = 3'b000;
  localparam logic [2:0] F3_RSVD = 3'b100;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [11:0] SYS_ECALL  = 12'h000;
  localparam logic [11:0] SYS_EBREAK = 12'h001;
  localparam logic [11:0] SYS_SRET   = 12'h102;
  localparam logic [11:0] SYS_WFI    = 12'h105;
  localparam logic [11:0] SYS_MRET   = 12'h302;

  localparam logic [11:0] MSTATUS  = 12'h300;
  localparam logic [11:0] MTVEC    = 12'h305;
  localparam logic [11:0] MEPC     = 12'h341;
  localparam logic [11:0] MCAUSE   = 12'h342;
  localparam logic [11:0] MTVAL    = 12'h343;
  localparam logic [11:0] MCYCLE   = 12'hB00;
  localparam logic [11:0] MINSTRET = 12'hB02;
  localparam logic [11:0] CYCLE    = 12'hC00;
  localparam logic [11:0] INSTRET  = 12'hC02;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_BREAK   = 32'd3;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  function automatic alu_op_e alu_dec(
    input logic [2:0] f3,
    input logic       alt,
    input logic       is_reg
  );
    unique case (f3)
      3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mem.sv
// Unified word memory: two combinational read ports, one byte-enabled
// write port. Contents are never reset.
module riscv_mem
  import riscv_pkg::*;
#(
  parameter int MEM_WORDS = 65536,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] faddr,
  output logic [31:0]   fdata,
  input  logic [AW-1:0] daddr,
  output logic [31:0]   ddata,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata
);

  logic [31:0] m [MEM_WORDS];
  logic [31:0] wword;

  assign fdata = m[faddr];
  assign ddata = m[daddr];

  always_comb begin
    wword = ddata;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) wword[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (we) m[daddr] <= wword;
  end

endmodule

// File: rtl/riscv_core.sv
// Single-cycle RV32I + Zicsr core with M-mode traps and embedded memory.
// Define RISCV_CORE_COUNTERS_EN for auto-incrementing mcycle/minstret.
module riscv_core
  import riscv_pkg::*;
#(
  parameter int          MEM_WORDS = 65536,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] pc;
  logic [31:0] rs  [32];
  logic [31:0] csr [4096];

  logic [31:0] instr, ddata;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1a, rs2a;
  logic [2:0]  f3;
  logic [11:0] csr_a;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1v, rs2v, pc4;

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic is_load, is_store, is_imm, is_op, is_fence, is_system;

  logic [31:0] op_a, op_b, alu_y;
  alu_op_e     alu_op;
  logic        take;
  logic [31:0] lshift, load_val;
  logic [3:0]  mask, mem_be;
  logic [31:0] mem_wdata;
  logic        mem_we;

  logic [31:0] csr_rdata, csr_src, csr_wdata, ms;
  logic [31:0] ms_trap, ms_mret;
  logic        csr_we, trap, is_mret, rd_we;
  logic [31:0] cause, rd_val, next_pc;

  riscv_mem #(
    .MEM_WORDS(MEM_WORDS),
    .AW       (AW)
  ) memory (
    .clk  (clk),
    .faddr(pc[AW+1:2]),
    .fdata(instr),
    .daddr(alu_y[AW+1:2]),
    .ddata(ddata),
    .we   (mem_we & rst),
    .be   (mem_be),
    .wdata(mem_wdata)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1a   = instr[19:15];
  assign rs2a   = instr[24:20];
  assign csr_a  = instr[31:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  assign rs1v = rs[rs1a];
  assign rs2v = rs[rs2a];
  assign pc4  = pc + 32'd4;

  assign is_lui    = opcode == OP_LUI;
  assign is_auipc  = opcode == OP_AUIPC;
  assign is_jal    = opcode == OP_JAL;
  assign is_jalr   = opcode == OP_JALR;
  assign is_branch = opcode == OP_BRANCH;
  assign is_load   = opcode == OP_LOAD;
  assign is_store  = opcode == OP_STORE;
  assign is_imm    = opcode == OP_IMM;
  assign is_op     = opcode == OP_OP;
  assign is_fence  = opcode == OP_FENCE;
  assign is_system = opcode == OP_SYSTEM;

  always_comb begin
    op_a   = rs1v;
    op_b   = imm_i;
    alu_op = ALU_ADD;
    unique case (1'b1)
      is_lui: begin
        op_a = '0;
        op_b = imm_u;
      end
      is_auipc: begin
        op_a = pc;
        op_b = imm_u;
      end
      is_store: op_b = imm_s;
      is_imm:   alu_op = alu_dec(f3, instr[30], 1'b0);
      is_op: begin
        op_b   = rs2v;
        alu_op = alu_dec(f3, instr[30], 1'b1);
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_y = '0;
    unique case (alu_op)
      ALU_ADD:  alu_y = op_a + op_b;
      ALU_SUB:  alu_y = op_a - op_b;
      ALU_SLL:  alu_y = op_a << op_b[4:0];
      ALU_SLT:  alu_y = {31'b0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_y = {31'b0, op_a < op_b};
      ALU_XOR:  alu_y = op_a ^ op_b;
      ALU_SRL:  alu_y = op_a >> op_b[4:0];
      ALU_SRA:  alu_y = $signed(op_a) >>> op_b[4:0];
      ALU_OR:   alu_y = op_a | op_b;
      ALU_AND:  alu_y = op_a & op_b;
      default:  alu_y = '0;
    endcase
  end

  always_comb begin
    case (f3)
      F3_BEQ:  take = rs1v == rs2v;
      F3_BNE:  take = rs1v != rs2v;
      F3_BLT:  take = $signed(rs1v) < $signed(rs2v);
      F3_BGE:  take = $signed(rs1v) >= $signed(rs2v);
      F3_BLTU: take = rs1v < rs2v;
      F3_BGEU: take = rs1v >= rs2v;
      default: take = 1'b0;
    endcase
  end

  // Sub-word accesses pick their lanes from addr[1:0], misaligned or not.
  assign lshift = ddata >> {alu_y[1:0], 3'b000};

  always_comb begin
    case (f3)
      F3_LB:   load_val = {{24{lshift[7]}}, lshift[7:0]};
      F3_LH:   load_val = {{16{lshift[15]}}, lshift[15:0]};
      F3_LBU:  load_val = {24'b0, lshift[7:0]};
      F3_LHU:  load_val = {16'b0, lshift[15:0]};
      default: load_val = lshift;
    endcase
  end

  always_comb begin
    case (f3[1:0])
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

  assign mem_be    = mask << alu_y[1:0];
  assign mem_wdata = rs2v << {alu_y[1:0], 3'b000};

`ifdef RISCV_CORE_COUNTERS_EN
  always_comb begin
    csr_rdata = csr[csr_a];
    if (csr_a == CYCLE) csr_rdata = csr[MCYCLE];
    else if (csr_a == INSTRET) csr_rdata = csr[MINSTRET];
  end
`else
  assign csr_rdata = csr[csr_a];
`endif

  assign csr_src = f3[2] ? {27'b0, rs1a} : rs1v;

  always_comb begin
    case (f3[1:0])
      2'b01:   csr_wdata = csr_src;
      2'b10:   csr_wdata = csr_rdata | csr_src;
      2'b11:   csr_wdata = csr_rdata & ~csr_src;
      default: csr_wdata = csr_rdata;
    endcase
  end

  assign ms      = csr[MSTATUS];
  assign ms_trap = {ms[31:13], 2'b11, ms[10:8], ms[3],
                    ms[6:4], 1'b0, ms[2:0]};
  assign ms_mret = {ms[31:8], 1'b1, ms[6:4], ms[7], ms[2:0]};

  always_comb begin
    rd_we   = 1'b0;
    rd_val  = alu_y;
    next_pc = pc4;
    mem_we  = 1'b0;
    trap    = 1'b0;
    cause   = CAUSE_ILLEGAL;
    is_mret = 1'b0;
    csr_we  = 1'b0;
    unique case (1'b1)
      is_lui, is_auipc, is_imm, is_op: rd_we = 1'b1;
      is_jal: begin
        rd_we   = 1'b1;
        rd_val  = pc4;
        next_pc = pc + imm_j;
      end
      is_jalr: begin
        rd_we   = 1'b1;
        rd_val  = pc4;
        next_pc = {alu_y[31:1], 1'b0};
      end
      is_branch: if (take) next_pc = pc + imm_b;
      is_load: begin
        rd_we  = 1'b1;
        rd_val = load_val;
      end
      is_store: mem_we = 1'b1;
      is_fence: ;
      is_system: begin
        if (f3 == F3_PRIV) begin
          case (csr_a)
            SYS_ECALL: begin
              trap  = 1'b1;
              cause = CAUSE_ECALL;
            end
            SYS_EBREAK: begin
              trap  = 1'b1;
              cause = CAUSE_BREAK;
            end
            SYS_MRET, SYS_SRET: begin
              is_mret = 1'b1;
              next_pc = csr[MEPC];
            end
            SYS_WFI: ;
            default: trap = 1'b1;
          endcase
        end else if (f3 == F3_RSVD) begin
          trap = 1'b1;
        end else begin
          rd_we  = 1'b1;
          rd_val = csr_rdata;
          csr_we = (f3[1:0] == 2'b01) || (rs1a != 5'd0);
        end
      end
      default: trap = 1'b1;
    endcase
    if (trap) next_pc = {csr[MTVEC][31:2], 2'b00};
  end

  // Later non-blocking writes win: an explicit CSR write beats the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) rs[i] <= '0;
      for (int i = 0; i < 4096; i++) csr[i] <= '0;
    end else begin
      pc <= next_pc;
      if (rd_we && rd != 5'd0) rs[rd] <= rd_val;
`ifdef RISCV_CORE_COUNTERS_EN
      csr[MCYCLE] <= csr[MCYCLE] + 32'd1;
      if (!trap) csr[MINSTRET] <= csr[MINSTRET] + 32'd1;
`endif
      if (csr_we) csr[csr_a] <= csr_wdata;
      if (trap) begin
        csr[MEPC]    <= pc;
        csr[MCAUSE]  <= cause;
        csr[MTVAL]   <= '0;
        csr[MSTATUS] <= ms_trap;
      end
      if (is_mret) csr[MSTATUS] <= ms_mret;
    end
  end

endmodule

// File: tb/tb_riscv_core.sv
// Directed and randomized program checks for riscv_core.
// Expected values come from an instruction-level model in this bench.
module tb_riscv_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total = 0;
  logic [31:0] prog [$];

  riscv_core dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] i_t(logic [31:0] imm, int s1,
                                      logic [2:0] f3, int rd, logic [6:0] op);
    return {imm[11:0], 5'(s1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] r_t(logic [6:0] f7, int s2, int s1,
                                      logic [2:0] f3, int rd);
    return {f7, 5'(s2), 5'(s1), f3, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] s_t(logic [31:0] imm, int s2, int s1,
                                      logic [2:0] f3);
    return {imm[11:5], 5'(s2), 5'(s1), f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_t(logic [31:0] imm, int s2, int s1,
                                      logic [2:0] f3);
    return {imm[12], imm[10:5], 5'(s2), 5'(s1), f3,
            imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] j_t(logic [31:0] imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'(rd), 7'h6f};
  endfunction

  function automatic logic [31:0] addi(int rd, int s1, logic [31:0] imm);
    return i_t(imm, s1, 3'd0, rd, 7'h13);
  endfunction

  function automatic logic [31:0] csri(int rd, logic [11:0] a,
                                       int s1, logic [2:0] f3);
    return {a, 5'(s1), f3, 5'(rd), 7'h73};
  endfunction

  task automatic p(input logic [31:0] w);
    prog.push_back(w);
  endtask

  task automatic li(input int r, input logic [31:0] v);
    logic [31:0] lo, hi;
    lo = {{20{v[11]}}, v[11:0]};
    hi = v - lo;
    p({hi[31:12], 5'(r), 7'h37});
    p(addi(r, r, lo));
  endtask

  task automatic load_and_reset();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 1024; i++) dut.memory.m[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.memory.m[i] = prog[i];
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] regs [32];

  task automatic rand_op();
    int kind, rd, s1, s2, sh;
    logic [31:0] a, b, simm, res, imm;
    kind = $urandom_range(0, 18);
    rd = $urandom_range(1, 7);
    s1 = $urandom_range(0, 7);
    s2 = $urandom_range(0, 7);
    sh = $urandom_range(0, 31);
    imm = 32'($urandom_range(0, 4095));
    simm = {{20{imm[11]}}, imm[11:0]};
    a = regs[s1];
    b = regs[s2];
    res = '0;
    case (kind)
      0: begin res = a + simm; p(i_t(imm, s1, 3'd0, rd, 7'h13)); end
      1: begin
        res = {31'b0, $signed(a) < $signed(simm)};
        p(i_t(imm, s1, 3'd2, rd, 7'h13));
      end
      2: begin res = {31'b0, a < simm}; p(i_t(imm, s1, 3'd3, rd, 7'h13)); end
      3: begin res = a ^ simm; p(i_t(imm, s1, 3'd4, rd, 7'h13)); end
      4: begin res = a | simm; p(i_t(imm, s1, 3'd6, rd, 7'h13)); end
      5: begin res = a & simm; p(i_t(imm, s1, 3'd7, rd, 7'h13)); end
      6: begin res = a << sh; p(i_t(32'(sh), s1, 3'd1, rd, 7'h13)); end
      7: begin res = a >> sh; p(i_t(32'(sh), s1, 3'd5, rd, 7'h13)); end
      8: begin
        res = $signed(a) >>> sh;
        p(i_t(32'h400 | 32'(sh), s1, 3'd5, rd, 7'h13));
      end
      9:  begin res = a + b; p(r_t(7'h00, s2, s1, 3'd0, rd)); end
      10: begin res = a - b; p(r_t(7'h20, s2, s1, 3'd0, rd)); end
      11: begin res = a << b[4:0]; p(r_t(7'h00, s2, s1, 3'd1, rd)); end
      12: begin
        res = {31'b0, $signed(a) < $signed(b)};
        p(r_t(7'h00, s2, s1, 3'd2, rd));
      end
      13: begin res = {31'b0, a < b}; p(r_t(7'h00, s2, s1, 3'd3, rd)); end
      14: begin res = a ^ b; p(r_t(7'h00, s2, s1, 3'd4, rd)); end
      15: begin res = a >> b[4:0]; p(r_t(7'h00, s2, s1, 3'd5, rd)); end
      16: begin
        res = $signed(a) >>> b[4:0];
        p(r_t(7'h20, s2, s1, 3'd5, rd));
      end
      17: begin res = a | b; p(r_t(7'h00, s2, s1, 3'd6, rd)); end
      default: begin res = a & b; p(r_t(7'h00, s2, s1, 3'd7, rd)); end
    endcase
    regs[rd] = res;
  endtask

  initial begin
    logic [2:0] bf3 [6];
    bf3[0] = 3'd0; bf3[1] = 3'd1; bf3[2] = 3'd4;
    bf3[3] = 3'd5; bf3[4] = 3'd6; bf3[5] = 3'd7;

    // ALU and branch basics
    prog.delete();
    p(addi(1, 0, 5));
    p(addi(2, 0, -3));
    p(r_t(7'h00, 2, 1, 3'd0, 3));
    p(b_t(8, 0, 3, 3'd1));
    p(addi(4, 0, 1));
    p(addi(5, 0, 7));
    p(addi(0, 0, 9));
    p(j_t(0, 0));
    load_and_reset();
    step(1);
    check("first_fetch_pc", dut.pc, 32'h4);
    check("first_fetch_x1", dut.rs[1], 32'd5);
    step(11);
    check("add_x3", dut.rs[3], 32'd2);
    check("bne_skip_x4", dut.rs[4], 32'd0);
    check("bne_target_x5", dut.rs[5], 32'd7);
    check("x0_zero", dut.rs[0], 32'd0);
    check("jal_loop_pc", dut.pc, 32'h1c);

    // randomized branches
    for (int it = 0; it < 8; it++) begin
      logic [31:0] a, b;
      logic [2:0] f3;
      logic t;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = ~a + 1;
      f3 = bf3[$urandom_range(0, 5)];
      case (f3)
        3'd0: t = a == b;
        3'd1: t = a != b;
        3'd4: t = $signed(a) < $signed(b);
        3'd5: t = $signed(a) >= $signed(b);
        3'd6: t = a < b;
        default: t = a >= b;
      endcase
      prog.delete();
      li(1, a);
      li(2, b);
      p(b_t(8, 2, 1, f3));
      p(addi(3, 0, 1));
      p(addi(4, 0, 1));
      p(j_t(0, 0));
      load_and_reset();
      step(9);
      check($sformatf("branch%0d_f3_%0d", it, f3), dut.rs[3], t ? 32'd0 : 32'd1);
      check($sformatf("branch%0d_after", it), dut.rs[4], 32'd1);
    end

    // randomized ALU sequences
    for (int r = 0; r < 3; r++) begin
      prog.delete();
      for (int k = 0; k < 32; k++) regs[k] = '0;
      for (int k = 1; k < 8; k++) begin
        regs[k] = $urandom;
        li(k, regs[k]);
      end
      for (int k = 0; k < 24; k++) rand_op();
      p(j_t(0, 0));
      load_and_reset();
      step(prog.size() + 2);
      for (int k = 0; k < 8; k++)
        check($sformatf("alu_r%0d_x%0d", r, k), dut.rs[k], regs[k]);
    end

    // loads and stores
    prog.delete();
    li(1, 32'h8765_4321);
    p(addi(2, 0, 32'h100));
    p(s_t(0, 1, 2, 3'd2));
    p(i_t(3, 2, 3'd0, 3, 7'h03));
    p(i_t(3, 2, 3'd4, 4, 7'h03));
    li(5, 32'h0000_BEEF);
    p(s_t(2, 5, 2, 3'd1));
    p(i_t(0, 2, 3'd2, 6, 7'h03));
    p(i_t(2, 2, 3'd1, 7, 7'h03));
    p(s_t(1, 5, 2, 3'd0));
    p(i_t(0, 2, 3'd2, 8, 7'h03));
    p({20'h80000, 5'd9, 7'h37});
    p(i_t(32'h100, 9, 3'd2, 10, 7'h03));
    p(i_t(2, 2, 3'd5, 11, 7'h03));
    p(j_t(0, 0));
    load_and_reset();
    step(18);
    check("lb_sext", dut.rs[3], 32'hFFFF_FF87);
    check("lbu_zext", dut.rs[4], 32'h0000_0087);
    check("sh_lane", dut.rs[6], 32'hBEEF_4321);
    check("lh_sext", dut.rs[7], 32'hFFFF_BEEF);
    check("sb_lane", dut.rs[8], 32'hBEEF_EF21);
    check("alias_lw", dut.rs[10], 32'hBEEF_EF21);
    check("lhu_zext", dut.rs[11], 32'h0000_BEEF);
    check("mem_word", dut.memory.m[32'h40], 32'hBEEF_EF21);

    // EBREAK trap and MRET
    prog.delete();
    p(addi(1, 0, 32'h200));
    p(csri(0, 12'h305, 1, 3'd1));
    p(csri(0, 12'h300, 8, 3'd6));
    p(csri(0, 12'h343, 1, 3'd1));
    while (prog.size() < 16) p(32'h0000_0013);
    p(32'h0010_0073);
    while (prog.size() < 128) p(32'h0);
    p(csri(7, 12'h342, 0, 3'd2));
    p(csri(8, 12'h341, 0, 3'd2));
    p(32'h3020_0073);
    load_and_reset();
    step(16);
    check("pre_trap_pc", dut.pc, 32'h40);
    check("pre_trap_mstatus", dut.csr[12'h300], 32'h8);
    step(1);
    check("ebreak_pc", dut.pc, 32'h200);
    check("ebreak_mepc", dut.csr[12'h341], 32'h40);
    check("ebreak_mcause", dut.csr[12'h342], 32'd3);
    check("ebreak_mtval", dut.csr[12'h343], 32'd0);
    check("ebreak_mstatus", dut.csr[12'h300], 32'h1880);
    step(3);
    check("mret_pc", dut.pc, 32'h40);
    check("csrr_mcause", dut.rs[7], 32'd3);
    check("csrr_mepc", dut.rs[8], 32'h40);
    check("mret_mstatus", dut.csr[12'h300], 32'h1888);
    check("csrrs_x0_nowrite", dut.csr[12'h342], 32'd3);

    // asynchronous reset mid-run
    rst = 1'b0;
    #1;
    begin
      int nz;
      nz = 0;
      for (int i = 0; i < 32; i++) if (dut.rs[i] !== 32'h0) nz++;
      check("reset_pc", dut.pc, 32'h0);
      check("reset_rs_nonzero", 32'(nz), 32'd0);
      check("reset_mtvec", dut.csr[12'h305], 32'h0);
      check("reset_mstatus", dut.csr[12'h300], 32'h0);
    end

    // ECALL then illegal opcode
    prog.delete();
    p(addi(1, 0, 32'h103));
    p(csri(0, 12'h305, 1, 3'd1));
    p(32'h0000_0073);
    load_and_reset();
    step(3);
    check("ecall_pc", dut.pc, 32'h100);
    check("ecall_mcause", dut.csr[12'h342], 32'd11);
    check("ecall_mepc", dut.csr[12'h341], 32'h8);
    step(1);
    check("illegal_mcause", dut.csr[12'h342], 32'd2);
    check("illegal_mepc", dut.csr[12'h341], 32'h100);
    check("illegal_pc", dut.pc, 32'h100);

    // sbreak-style self test
    prog.delete();
    p(addi(1, 0, 32'h80));
    p(csri(0, 12'h305, 1, 3'd1));
    p(32'h0010_0073);
    p(j_t(0, 0));
    while (prog.size() < 32) p(32'h0);
    p(csri(2, 12'h342, 0, 3'd2));
    p(addi(4, 0, 3));
    p(b_t(8, 4, 2, 3'd1));
    p(addi(3, 0, 1));
    p(j_t(0, 0));
    load_and_reset();
    step(5000);
    check("compliance_gp", dut.rs[3], 32'd1);

    // counters
    prog.delete();
    for (int k = 0; k < 10; k++) p(addi(1, 1, 1));
    p(csri(5, 12'hB00, 0, 3'd2));
    p(csri(6, 12'hB02, 0, 3'd2));
    p(csri(7, 12'hC00, 0, 3'd2));
    p(j_t(0, 0));
    load_and_reset();
    step(14);
    check("cnt_addis", dut.rs[1], 32'd10);
`ifdef RISCV_CORE_COUNTERS_EN
    check("mcycle", dut.rs[5], 32'd10);
    check("minstret", dut.rs[6], 32'd11);
    check("cycle_alias", dut.rs[7], 32'd12);
`else
    check("mcycle_plain", dut.rs[5], 32'd0);
    check("minstret_plain", dut.rs[6], 32'd0);
    check("cycle_plain", dut.rs[7], 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
